branch_predictor_btb: RTL

//  Parametrised branch target buffer with per-entry saturating counters for the 5-stage RV32I pipeline.
//  - Predicts taken/target in IF, in the same cycle as the fetch PC.
//  - Is trained from EX/MEM branch resolution.
//  - Replaces the fixed predict-not-taken/flush-on-PCSrc scheme with a direct-mapped, DEPTH-entry predictor.
//  - Flags mispredicts and supplies the redirect PC.

---
 rtl/riscv_bp_pkg.sv | 28 ++
 rtl/sat_counter_upd.sv | 23 ++
 rtl/branch_predictor_btb.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/riscv_bp_pkg.sv
// Shared constants, counter-encoding helpers and the BTB entry layout
// for the default predictor configuration.
package riscv_bp_pkg;

  localparam int unsigned PC_INC       = 4;
  localparam int unsigned BP_WORD_BITS = 32;
  localparam int unsigned BP_ENTRIES   = 16;
  localparam int unsigned BP_CTR_BITS  = 2;
  localparam int unsigned BP_STAT_BITS = 32;
  localparam int unsigned BP_IDX_BITS  = $clog2(BP_ENTRIES);
  localparam int unsigned BP_TAG_BITS  = BP_WORD_BITS - BP_IDX_BITS - 2;

  function automatic int unsigned ctr_weak_taken(input int unsigned cb);
    return 32'd1 << (cb - 1);
  endfunction

  function automatic int unsigned ctr_weak_not_taken(input int unsigned cb);
    return (32'd1 << (cb - 1)) - 32'd1;
  endfunction

  typedef struct packed {
    logic                    valid;
    logic [BP_TAG_BITS-1:0]  tag;
    logic [BP_WORD_BITS-1:0] target;
    logic [BP_CTR_BITS-1:0]  ctr;
  } btb_entry_t;

endpackage

// File: rtl/sat_counter_upd.sv
// Combinational next value of a saturating up/down counter.
module sat_counter_upd #(
  parameter int unsigned COUNTER_BITS = 2
) (
  input  logic [COUNTER_BITS-1:0] ctr_i,
  input  logic                    inc_i,
  output logic [COUNTER_BITS-1:0] ctr_o
);

  localparam logic [COUNTER_BITS-1:0] CTR_MAX = '1;
  localparam logic [COUNTER_BITS-1:0] CTR_MIN = '0;
  localparam logic [COUNTER_BITS-1:0] CTR_ONE = COUNTER_BITS'(1);

  always_comb begin
    ctr_o = ctr_i;
    if (inc_i) begin
      if (ctr_i != CTR_MAX) ctr_o = ctr_i + CTR_ONE;
    end else begin
      if (ctr_i != CTR_MIN) ctr_o = ctr_i - CTR_ONE;
    end
  end

endmodule

// File: rtl/branch_predictor_btb.sv
// Direct-mapped branch target buffer: same-cycle IF prediction, training from
// branch resolution, mispredict detection and redirect PC generation.
module branch_predictor_btb
  import riscv_bp_pkg::*;
#(
  parameter int unsigned WORD_BITWIDTH = BP_WORD_BITS,
  parameter int unsigned BTB_ENTRIES   = BP_ENTRIES,
  parameter int unsigned COUNTER_BITS  = BP_CTR_BITS,
  parameter int unsigned STAT_BITWIDTH = BP_STAT_BITS
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     lookup_valid,
  input  logic [WORD_BITWIDTH-1:0] lookup_pc,
  output logic                     pred_taken,
  output logic [WORD_BITWIDTH-1:0] pred_target,
  input  logic                     upd_valid,
  input  logic [WORD_BITWIDTH-1:0] upd_pc,
  input  logic                     upd_taken,
  input  logic [WORD_BITWIDTH-1:0] upd_target,
  input  logic                     upd_pred_taken,
  input  logic [WORD_BITWIDTH-1:0] upd_pred_target,
  input  logic                     flush_btb,
  output logic                     mispredict,
  output logic [WORD_BITWIDTH-1:0] redirect_pc,
  output logic [STAT_BITWIDTH-1:0] stat_lookups,
  output logic [STAT_BITWIDTH-1:0] stat_mispredicts
);

  localparam int unsigned IDX_BITS = $clog2(BTB_ENTRIES);
  localparam int unsigned TAG_BITS = WORD_BITWIDTH - IDX_BITS - 2;
  localparam logic [COUNTER_BITS-1:0]  CTR_WT  = COUNTER_BITS'(ctr_weak_taken(COUNTER_BITS));
  localparam logic [COUNTER_BITS-1:0]  CTR_WNT = COUNTER_BITS'(ctr_weak_not_taken(COUNTER_BITS));
  localparam logic [WORD_BITWIDTH-1:0] INC     = WORD_BITWIDTH'(PC_INC);
  localparam logic [STAT_BITWIDTH-1:0] STAT_MAX = '1;
  localparam logic [STAT_BITWIDTH-1:0] STAT_ONE = STAT_BITWIDTH'(1);

  logic [BTB_ENTRIES-1:0]                    valid_vec;
  logic [BTB_ENTRIES-1:0][TAG_BITS-1:0]      tag_vec;
  logic [BTB_ENTRIES-1:0][WORD_BITWIDTH-1:0] target_vec;
  logic [BTB_ENTRIES-1:0][COUNTER_BITS-1:0]  ctr_vec;

  logic [IDX_BITS-1:0]     lk_idx;
  logic [TAG_BITS-1:0]     lk_tag;
  logic                    lk_hit;
  logic [IDX_BITS-1:0]     upd_idx;
  logic [TAG_BITS-1:0]     upd_tag;
  logic                    upd_hit;
  logic [COUNTER_BITS-1:0] ctr_upd;

  assign lk_idx  = lookup_pc[IDX_BITS+1:2];
  assign lk_tag  = lookup_pc[WORD_BITWIDTH-1:IDX_BITS+2];
  assign lk_hit  = valid_vec[lk_idx] & (tag_vec[lk_idx] == lk_tag);
  assign upd_idx = upd_pc[IDX_BITS+1:2];
  assign upd_tag = upd_pc[WORD_BITWIDTH-1:IDX_BITS+2];
  assign upd_hit = valid_vec[upd_idx] & (tag_vec[upd_idx] == upd_tag);

  // Lookup reads registered state only, so a same-cycle update is not bypassed.
  assign pred_taken  = lookup_valid & lk_hit & ctr_vec[lk_idx][COUNTER_BITS-1];
  assign pred_target = pred_taken ? target_vec[lk_idx] : lookup_pc + INC;

  assign mispredict  = upd_valid & ((upd_pred_taken != upd_taken) |
                                    (upd_taken & (upd_pred_target != upd_target)));
  assign redirect_pc = upd_taken ? upd_target : upd_pc + INC;

  sat_counter_upd #(
    .COUNTER_BITS(COUNTER_BITS)
  ) u_sat_counter_upd (
    .ctr_i (ctr_vec[upd_idx]),
    .inc_i (upd_taken),
    .ctr_o (ctr_upd)
  );

  for (genvar gi = 0; gi < BTB_ENTRIES; gi++) begin : g_entry
    logic                     valid_q, valid_d;
    logic [TAG_BITS-1:0]      tag_q, tag_d;
    logic [WORD_BITWIDTH-1:0] target_q, target_d;
    logic [COUNTER_BITS-1:0]  ctr_q, ctr_d;
    logic                     sel;

    assign sel = upd_valid & (upd_idx == IDX_BITS'(gi));

    // Flush only clears valid bits and suppresses any training in that cycle.
    always_comb begin
      valid_d  = valid_q;
      tag_d    = tag_q;
      target_d = target_q;
      ctr_d    = ctr_q;
      if (flush_btb) begin
        valid_d = 1'b0;
      end else if (sel) begin
        if (upd_hit) begin
          ctr_d = ctr_upd;
          if (upd_taken) target_d = upd_target;
        end else if (upd_taken) begin
          valid_d  = 1'b1;
          tag_d    = upd_tag;
          target_d = upd_target;
          ctr_d    = CTR_WT;
        end
      end
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        valid_q  <= 1'b0;
        tag_q    <= '0;
        target_q <= '0;
        ctr_q    <= CTR_WNT;
      end else begin
        valid_q  <= valid_d;
        tag_q    <= tag_d;
        target_q <= target_d;
        ctr_q    <= ctr_d;
      end
    end

    assign valid_vec[gi]  = valid_q;
    assign tag_vec[gi]    = tag_q;
    assign target_vec[gi] = target_q;
    assign ctr_vec[gi]    = ctr_q;
  end

  logic [STAT_BITWIDTH-1:0] stat_lookups_q, stat_lookups_d;
  logic [STAT_BITWIDTH-1:0] stat_mispredicts_q, stat_mispredicts_d;

  always_comb begin
    stat_lookups_d     = stat_lookups_q;
    stat_mispredicts_d = stat_mispredicts_q;
    if (lookup_valid && stat_lookups_q != STAT_MAX)
      stat_lookups_d = stat_lookups_q + STAT_ONE;
    if (mispredict && stat_mispredicts_q != STAT_MAX)
      stat_mispredicts_d = stat_mispredicts_q + STAT_ONE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stat_lookups_q     <= '0;
      stat_mispredicts_q <= '0;
    end else begin
      stat_lookups_q     <= stat_lookups_d;
      stat_mispredicts_q <= stat_mispredicts_d;
    end
  end

  assign stat_lookups     = stat_lookups_q;
  assign stat_mispredicts = stat_mispredicts_q;

endmodule
